link_arbiter: RTL and testbench

Round-robin scheduler that shares one outbound 8-bit router link between `NUM_REQ` packet sources, such as the node FIFO and local router input buffers. It picks one requester, latches its 32-bit `pkt_t`, and serialises it MSB-first as four byte transfers on the `free`/`put`/`payload` link handshake. It also keeps per-requester sent-packet counters for debug and bench checking.

---
 rtl/link_arbiter_pkg.sv | 25 ++
 rtl/link_arbiter_rr_picker.sv | 28 ++
 rtl/link_arbiter.sv | 108 ++++++++++
 tb/tb_link_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/link_arbiter_pkg.sv
// rtl/link_arbiter_pkg.sv - shared types for the outbound link arbiter
package link_arbiter_pkg;

  typedef logic [31:0] pkt_t;

  localparam int PKT_BYTES = 4;

  typedef enum logic {
    IDLE,
    SEND
  } arb_state_t;

  // Byte idx of a packet, MSB first (idx 0 -> [31:24]).
  function automatic logic [7:0] pkt_byte(input pkt_t p, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = p[31:24];
      2'd1:    b = p[23:16];
      2'd2:    b = p[15:8];
      default: b = p[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/link_arbiter_rr_picker.sv
// rtl/link_arbiter_rr_picker.sv - combinational round-robin winner search
module rr_picker
  import link_arbiter_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] elig,
  input  logic [IDW-1:0]     last,
  output logic [IDW-1:0]     winner,
  output logic               valid
);

  // Search starts just after the previous winner so it gets lowest priority.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      logic [IDW-1:0] idx;
      idx = IDW'((int'(last) + k) % NUM_REQ);
      if (!valid && elig[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/link_arbiter.sv
// rtl/link_arbiter.sv - round-robin arbiter serialising 32-bit packets onto an 8-bit link
module link_arbiter
  import link_arbiter_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*32-1:0] pkt,
  input  logic [NUM_REQ-1:0]   req_en,
  output logic [NUM_REQ-1:0]   taken,
  input  logic                 free_outbound,
  output logic                 put_outbound,
  output logic [7:0]           payload_outbound,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id,
  output logic [NUM_REQ*8-1:0] sent_count
);

  arb_state_t                    state_q;
  logic [1:0]                    bcnt_q;
  pkt_t                          shreg_q;
  logic [IDW-1:0]                last_q;
  logic [IDW-1:0]                grant_q;
  logic                          put_q;
  logic [7:0]                    payload_q;
  logic [NUM_REQ-1:0]            taken_q;
  logic [NUM_REQ-1:0][7:0]       cnt_q;

  logic [NUM_REQ-1:0][31:0]      pkt_v;
  logic [NUM_REQ-1:0]            elig_d;
  logic [NUM_REQ-1:0]            taken_d;
  logic [IDW-1:0]                winner;
  logic                          win_valid;
  pkt_t                          pkt_w;

  assign pkt_v  = pkt;
  assign elig_d = req & req_en;
  assign pkt_w  = pkt_v[winner];

  always_comb begin
    taken_d         = '0;
    taken_d[winner] = 1'b1;
  end

  rr_picker #(
    .NUM_REQ(NUM_REQ)
  ) u_picker (
    .elig  (elig_d),
    .last  (last_q),
    .winner(winner),
    .valid (win_valid)
  );

  // bcnt wraps 3 -> 0 after the last byte; 0 in SEND marks the closing edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      bcnt_q    <= '0;
      shreg_q   <= '0;
      last_q    <= IDW'(NUM_REQ - 1);
      grant_q   <= '0;
      put_q     <= 1'b0;
      payload_q <= '0;
      taken_q   <= '0;
      cnt_q     <= '0;
    end else begin
      taken_q <= '0;
      case (state_q)
        IDLE: begin
          if (win_valid && free_outbound) begin
            shreg_q   <= pkt_w;
            payload_q <= pkt_byte(pkt_w, 2'd0);
            put_q     <= 1'b1;
            taken_q   <= taken_d;
            last_q    <= winner;
            grant_q   <= winner;
            bcnt_q    <= 2'd1;
            state_q   <= SEND;
          end else begin
            put_q <= 1'b0;
          end
        end
        SEND: begin
          if (bcnt_q == 2'd0) begin
            put_q          <= 1'b0;
            cnt_q[grant_q] <= cnt_q[grant_q] + 8'd1;
            state_q        <= IDLE;
          end else begin
            payload_q <= pkt_byte(shreg_q, bcnt_q);
            bcnt_q    <= bcnt_q + 2'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign taken            = taken_q;
  assign put_outbound     = put_q;
  assign payload_outbound = payload_q;
  assign busy             = (state_q == SEND);
  assign grant_id         = grant_q;
  assign sent_count       = cnt_q;

endmodule

// File: tb/tb_link_arbiter.sv
// tb/tb_link_arbiter.sv - directed self-checking bench for link_arbiter
module tb_link_arbiter;

  localparam int N = 4;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*32-1:0] pkt;
  logic [N-1:0]   req_en;
  logic [N-1:0]   taken;
  logic           free_outbound;
  logic           put_outbound;
  logic [7:0]     payload_outbound;
  logic           busy;
  logic [1:0]     grant_id;
  logic [N*8-1:0] sent_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  link_arbiter #(.NUM_REQ(N)) dut (
    .clock           (clock),
    .reset           (reset),
    .req             (req),
    .pkt             (pkt),
    .req_en          (req_en),
    .taken           (taken),
    .free_outbound   (free_outbound),
    .put_outbound    (put_outbound),
    .payload_outbound(payload_outbound),
    .busy            (busy),
    .grant_id        (grant_id),
    .sent_count      (sent_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset;
    req   = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic drain;
    req = '0;
    for (int i = 0; i < 5; i++) tick();
  endtask

  initial begin
    reset         = 1'b1;
    req           = '0;
    req_en        = 4'hF;
    free_outbound = 1'b1;
    pkt           = '0;
    @(negedge clock);
    tick();
    tick();
    check_eq("rst_put",   32'(put_outbound), 32'd0);
    check_eq("rst_taken", 32'(taken), 32'd0);
    check_eq("rst_busy",  32'(busy), 32'd0);
    check_eq("rst_pay",   32'(payload_outbound), 32'd0);
    check_eq("rst_gid",   32'(grant_id), 32'd0);
    check_eq("rst_cnt",   sent_count, 32'd0);
    reset = 1'b0;

    // Single packet
    pkt[31:0] = 32'hA1B2C3D4;
    req       = 4'b0001;
    tick();
    check_eq("sp_taken", 32'(taken), 32'h1);
    check_eq("sp_put0",  32'(put_outbound), 32'd1);
    check_eq("sp_b0",    32'(payload_outbound), 32'hA1);
    check_eq("sp_busy",  32'(busy), 32'd1);
    req = '0;
    tick();
    check_eq("sp_b1",     32'(payload_outbound), 32'hB2);
    check_eq("sp_taken1", 32'(taken), 32'h0);
    tick();
    check_eq("sp_b2", 32'(payload_outbound), 32'hC3);
    tick();
    check_eq("sp_b3",   32'(payload_outbound), 32'hD4);
    check_eq("sp_put3", 32'(put_outbound), 32'd1);
    tick();
    check_eq("sp_put4",  32'(put_outbound), 32'd0);
    check_eq("sp_busy4", 32'(busy), 32'd0);
    check_eq("sp_cnt",   sent_count, 32'h00000001);

    // Round-robin under full load
    do_reset();
    pkt = {32'h40414243, 32'h30313233, 32'h20212223, 32'h10111213};
    req = 4'hF;
    for (int n = 0; n < 21; n++) begin
      tick();
      check_eq($sformatf("rr_put%0d", n), 32'(put_outbound), 32'((n % 5) != 4));
      check_eq($sformatf("rr_busy%0d", n), 32'(busy), 32'((n % 5) != 4));
      if (n % 5 == 0) begin
        check_eq($sformatf("rr_taken%0d", n), 32'(taken), 32'(1 << ((n / 5) % 4)));
        check_eq($sformatf("rr_b0_%0d", n), 32'(payload_outbound), 32'(8'h10 + 8'h10 * ((n / 5) % 4)));
      end
      if (n == 19) check_eq("rr_cnt", sent_count, 32'h01010101);
    end
    drain();

    // Mask: only 1 and 3 eligible; drop 3 mid-packet
    do_reset();
    req    = 4'hF;
    req_en = 4'b1010;
    tick();
    check_eq("mk_taken0", 32'(taken), 32'b0010);
    for (int i = 0; i < 4; i++) tick();
    tick();
    check_eq("mk_taken1", 32'(taken), 32'b1000);
    req_en = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("mk_put%0d", i), 32'(put_outbound), 32'd1);
    end
    tick();
    check_eq("mk_putlow", 32'(put_outbound), 32'd0);
    check_eq("mk_cnt",    sent_count, 32'h01000100);
    tick();
    check_eq("mk_taken2", 32'(taken), 32'b0010);
    req_en = 4'hF;
    drain();

    // Backpressure
    do_reset();
    pkt[95:64]    = 32'h5A6B7C8D;
    req           = 4'b0100;
    free_outbound = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq($sformatf("bp_put%0d", i), 32'(put_outbound), 32'd0);
      check_eq($sformatf("bp_taken%0d", i), 32'(taken), 32'd0);
    end
    free_outbound = 1'b1;
    tick();
    check_eq("bp_taken", 32'(taken), 32'b0100);
    check_eq("bp_b0",    32'(payload_outbound), 32'h5A);
    check_eq("bp_gid",   32'(grant_id), 32'd2);
    drain();
    check_eq("bp_cnt", sent_count, 32'h00010000);

    // Reset mid-packet
    do_reset();
    pkt[31:0] = 32'h11223344;
    req       = 4'b0001;
    tick();
    check_eq("mr_b0", 32'(payload_outbound), 32'h11);
    req = '0;
    tick();
    check_eq("mr_b1", 32'(payload_outbound), 32'h22);
    reset = 1'b1;
    tick();
    check_eq("mr_put",   32'(put_outbound), 32'd0);
    check_eq("mr_taken", 32'(taken), 32'd0);
    check_eq("mr_busy",  32'(busy), 32'd0);
    check_eq("mr_pay",   32'(payload_outbound), 32'd0);
    check_eq("mr_gid",   32'(grant_id), 32'd0);
    check_eq("mr_cnt",   sent_count, 32'd0);
    reset = 1'b0;
    req   = 4'b0011;
    tick();
    check_eq("mr_first", 32'(taken), 32'b0001);
    drain();

    // Counter wrap on requester 1
    do_reset();
    pkt[63:32] = 32'hCAFEF00D;
    req        = 4'b0010;
    for (int i = 0; i < 255 * 5; i++) tick();
    check_eq("wr_255", 32'(sent_count[15:8]), 32'd255);
    for (int i = 0; i < 5; i++) tick();
    check_eq("wr_0",   32'(sent_count[15:8]), 32'd0);
    check_eq("wr_gid", 32'(grant_id), 32'd1);
    req = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
